// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
// Bus-mapped SPI mode-0 responder. All SPI pins are oversampled by clk_i,
// so the block is fully synchronous. The CPU preloads reply bytes through
// TX_BYTE and drains received bytes through RX_BYTE on the shared
// address/data/rd_wr register bus.
//
// Ports:
//   clk_i          system clock (only clock)
//   reset_ni       asynchronous active-low reset
//   address_i      register address
//   data_i         write data
//   data_o         read data, registered (0 for unmapped / write-only reads)
//   rd_wr_i        1 = write, 0 = read
//   spi_clk_i      SCLK from master
//   spi_mosi_i     master-out data
//   spi_sync_ni    active-low frame select
//   spi_miso_o     slave-out data, registered
//   spi_miso_oe_o  MISO output enable, high only while selected
//
// Register window (offset * Address_Wording from BaseAddress):
//   +0 TX_BYTE  (W)  shift a byte into the reply word for the next frame
//   +1 RX_BYTE  (R)  pop the most significant received byte, clears rx_valid
//   +2 STATUS   (R)  {4'b0, frame_error, overrun, rx_valid, busy}
//   +3 CLEAR    (W)  bit2 clears overrun, bit3 clears frame_error
// -----------------------------------------------------------------------------
module spi_slave #(
  parameter int BaseAddress         = 0,
  parameter int BytesPerTransaction = 1,
  parameter int FPGAClkSpeed        = 50000000,
  parameter int SPIClkSpeed         = 1000,
  parameter int address_width       = 16,
  parameter int data_width          = 8,
  parameter int Address_Wording     = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic [address_width-1:0] address_i,
  input  logic [data_width-1:0]    data_i,
  output logic [data_width-1:0]    data_o,
  input  logic                     rd_wr_i,
  input  logic                     spi_clk_i,
  input  logic                     spi_mosi_i,
  input  logic                     spi_sync_ni,
  output logic                     spi_miso_o,
  output logic                     spi_miso_oe_o
);

  localparam int W  = BytesPerTransaction * 8;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] BITS_FULL = CW'(W);

  localparam logic [address_width-1:0] ADDR_TX  = address_width'(BaseAddress);
  localparam logic [address_width-1:0] ADDR_RX  = address_width'(BaseAddress + Address_Wording);
  localparam logic [address_width-1:0] ADDR_ST  = address_width'(BaseAddress + 2 * Address_Wording);
  localparam logic [address_width-1:0] ADDR_CLR = address_width'(BaseAddress + 3 * Address_Wording);

  // Parameter sanity: the oversampling pipeline needs a fast enough clk_i.
  generate
    if (FPGAClkSpeed < 8 * SPIClkSpeed) begin : g_clk_ratio_check
      $error("spi_slave: FPGAClkSpeed must be at least 8*SPIClkSpeed");
    end
    if ((BytesPerTransaction < 1) || (BytesPerTransaction > 16)) begin : g_bytes_check
      $error("spi_slave: BytesPerTransaction must be within 1..16");
    end
    if (data_width < 8) begin : g_width_check
      $error("spi_slave: data_width must be at least 8");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_ACTIVE     = 2'd1,
    S_DONE       = 2'd2,
    S_WAIT_DESEL = 2'd3
  } state_t;

  state_t state_r;
  state_t next_state_s;

  // Synchroniser / edge-history registers
  logic       sclk_meta_r, sclk_sync_r, sclk_prev_r;
  logic       sync_meta_r, sync_sync_r, sync_prev_r;
  logic       mosi_meta_r, mosi_sync_r;
  logic [1:0] prime_r;
  logic       armed_r;

  // Frame datapath
  logic [W-1:0]  tx_shift_r;
  logic [W-1:0]  rx_shift_r;
  logic [CW-1:0] bit_cnt_r;
  logic          miso_r;
  logic          miso_oe_r;

  // CPU-visible state
  logic [W-1:0]          tx_data_r;
  logic [W-1:0]          rx_copy_r;
  logic                  rx_valid_r;
  logic                  overrun_r;
  logic                  frame_error_r;
  logic [data_width-1:0] data_r;
  logic [data_width-1:0] rd_data_s;

  // Decoded events
  logic       sclk_rise_s, sclk_fall_s, sync_fall_s, sync_high_s;
  logic       wr_tx_s, rd_rx_s, rd_st_s, wr_clr_s;
  logic       done_s, abort_s, busy_s, frame_full_s;
  logic [7:0] status_s;

  // Two-stage synchronisers plus one edge-history register per SPI pin.
  // prime_r/armed_r make sure a falling sync edge is only accepted after sync
  // has really been seen high, so a frame already running at reset release
  // is never joined halfway.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sclk_meta_r <= 1'b0;
      sclk_sync_r <= 1'b0;
      sclk_prev_r <= 1'b0;
      sync_meta_r <= 1'b1;
      sync_sync_r <= 1'b1;
      sync_prev_r <= 1'b1;
      mosi_meta_r <= 1'b0;
      mosi_sync_r <= 1'b0;
      prime_r     <= 2'b00;
      armed_r     <= 1'b0;
    end else begin
      sclk_meta_r <= spi_clk_i;
      sclk_sync_r <= sclk_meta_r;
      sclk_prev_r <= sclk_sync_r;
      sync_meta_r <= spi_sync_ni;
      sync_sync_r <= sync_meta_r;
      sync_prev_r <= sync_sync_r;
      mosi_meta_r <= spi_mosi_i;
      mosi_sync_r <= mosi_meta_r;
      prime_r     <= {prime_r[0], 1'b1};
      armed_r     <= armed_r | (prime_r[1] & sync_sync_r);
    end
  end

  assign sclk_rise_s  = sclk_sync_r & ~sclk_prev_r;
  assign sclk_fall_s  = ~sclk_sync_r & sclk_prev_r;
  assign sync_fall_s  = armed_r & sync_prev_r & ~sync_sync_r;
  assign sync_high_s  = sync_sync_r;
  assign frame_full_s = (bit_cnt_r == BITS_FULL);

  assign wr_tx_s  = rd_wr_i  && (address_i == ADDR_TX);
  assign rd_rx_s  = !rd_wr_i && (address_i == ADDR_RX);
  assign rd_st_s  = !rd_wr_i && (address_i == ADDR_ST);
  assign wr_clr_s = rd_wr_i  && (address_i == ADDR_CLR);

  assign busy_s   = (state_r != S_IDLE);
  assign done_s   = (state_r == S_DONE);
  assign abort_s  = (state_r == S_ACTIVE) && (next_state_s == S_IDLE);
  assign status_s = {4'b0000, frame_error_r, overrun_r, rx_valid_r, busy_s};

  // Frame state register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; an early deselect aborts, a full frame completes once SCLK is low.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (sync_fall_s) begin
          next_state_s = S_ACTIVE;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_ACTIVE: begin
        if (!frame_full_s && sync_high_s) begin
          next_state_s = S_IDLE;
        end else if (frame_full_s && !sclk_sync_r) begin
          next_state_s = S_DONE;
        end else begin
          next_state_s = S_ACTIVE;
        end
      end
      S_DONE: begin
        next_state_s = S_WAIT_DESEL;
      end
      S_WAIT_DESEL: begin
        if (sync_high_s) begin
          next_state_s = S_IDLE;
        end else begin
          next_state_s = S_WAIT_DESEL;
        end
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  // Shift registers, bit counter and MISO drive for the running frame.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      tx_shift_r <= {W{1'b0}};
      rx_shift_r <= {W{1'b0}};
      bit_cnt_r  <= {CW{1'b0}};
      miso_r     <= 1'b0;
      miso_oe_r  <= 1'b0;
    end else begin
      miso_oe_r <= (next_state_s != S_IDLE);
      case (state_r)
        S_IDLE: begin
          bit_cnt_r <= {CW{1'b0}};
          if (sync_fall_s) begin
            tx_shift_r <= tx_data_r;
            miso_r     <= tx_data_r[W-1];
          end
        end
        S_ACTIVE: begin
          // Extra edges past the last bit are ignored so the counter cannot wrap.
          if (sclk_rise_s && !frame_full_s) begin
            rx_shift_r <= {rx_shift_r[W-2:0], mosi_sync_r};
            bit_cnt_r  <= bit_cnt_r + CW'(1);
          end else if (sclk_fall_s && !frame_full_s) begin
            tx_shift_r <= {tx_shift_r[W-2:0], 1'b0};
            miso_r     <= tx_shift_r[W-2];
          end
        end
        S_WAIT_DESEL: begin
          if (sync_high_s) begin
            miso_r <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // CPU-visible registers; a completing frame and a TX write in the same
  // cycle leave the written byte in tx_data, and a completing frame beats an
  // RX read (the read sees the old byte and does not flag overrun).
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      tx_data_r     <= {W{1'b0}};
      rx_copy_r     <= {W{1'b0}};
      rx_valid_r    <= 1'b0;
      overrun_r     <= 1'b0;
      frame_error_r <= 1'b0;
    end else begin
      if (wr_tx_s) begin
        tx_data_r <= (tx_data_r << 8) | W'(data_i[7:0]);
      end else if (done_s) begin
        tx_data_r <= {W{1'b0}};
      end

      if (done_s) begin
        rx_copy_r  <= rx_shift_r;
        rx_valid_r <= 1'b1;
      end else if (rd_rx_s) begin
        rx_copy_r  <= rx_copy_r << 8;
        rx_valid_r <= 1'b0;
      end

      if (done_s && rx_valid_r && !rd_rx_s) begin
        overrun_r <= 1'b1;
      end else if (wr_clr_s && data_i[2]) begin
        overrun_r <= 1'b0;
      end

      if (abort_s) begin
        frame_error_r <= 1'b1;
      end else if (wr_clr_s && data_i[3]) begin
        frame_error_r <= 1'b0;
      end
    end
  end

  // Read-data mux; unmapped addresses and write-only registers read as zero.
  always_comb begin
    rd_data_s = {data_width{1'b0}};
    if (rd_rx_s) begin
      rd_data_s = data_width'(rx_copy_r[W-1 -: 8]);
    end else if (rd_st_s) begin
      rd_data_s = data_width'(status_s);
    end else begin
      rd_data_s = {data_width{1'b0}};
    end
  end

  // Registered read data.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      data_r <= {data_width{1'b0}};
    end else begin
      data_r <= rd_data_s;
    end
  end

  assign data_o        = data_r;
  assign spi_miso_o    = miso_r;
  assign spi_miso_oe_o = miso_oe_r;

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- Bus-mapped SPI responder (mode 0: SCLK idles low, MOSI sampled on the rising edge, MISO changed on the falling edge, MSB first, active-low sync). It is the far end of the existing SPI master.
- A frame is BytesPerTransaction*8 bits.
- The CPU preloads reply bytes and reads back received bytes through the same address/data/rd_wr register bus used by the other peripherals.
- All SPI inputs are oversampled by clk_i, so the block is fully synchronous.

Parameters:
- BaseAddress, 0, base of the 4-register window.
- BytesPerTransaction, 1, bytes per frame (1..16).
- FPGAClkSpeed, 50000000, clk_i frequency in Hz.
- SPIClkSpeed, 1000, maximum SCLK in Hz. Elaboration raises $error if FPGAClkSpeed < 8*SPIClkSpeed.
- address_width, 16, bus address width.
- data_width, 8, bus data width.
- Address_Wording, 1, address stride between registers.

Ports:
- clk_i  in  1  system clock. Only clock: one clock; reset is asynchronous and active-low.
- reset_ni  in  1  asynchronous active-low reset.
- address_i  in  address_width  register address.
- data_i  in  data_width  write data.
- data_o  out  data_width  read data, registered.
- rd_wr_i  in  1  1 = write, 0 = read.
- spi_clk_i  in  1  SCLK from master.
- spi_mosi_i  in  1  master-out data.
- spi_sync_ni  in  1  active-low frame select.
- spi_miso_o  out  1  slave-out data.
- spi_miso_oe_o  out  1  MISO output enable; 1 only while selected.

Behaviour:
- Register map (offset*Address_Wording from BaseAddress):
  - +0 TX_BYTE (write): tx_data <= {tx_data[N*8-9:0], data_i[7:0]}. For N = 1, tx_data <= data_i[7:0].
  - +1 RX_BYTE (read): data_o <= rx_copy[MSB byte]; rx_copy <<= 8; rx_valid <= 0.
  - +2 STATUS (read): data_o = {4'b0, frame_error, overrun, rx_valid, busy}.
  - +3 CLEAR (write): data_i[2] clears overrun; data_i[3] clears frame_error.
  - Any other address, or a read of a write-only register: data_o <= 0, no side effects.
- Input conditioning:
  - spi_clk_i, spi_mosi_i and spi_sync_ni each pass through a 2-FF synchroniser plus one edge-detect register.
  - SCLK edge to internal action latency: 3 clk_i cycles.
- State machine:
  - IDLE: miso_oe = 0, busy = 0, bit_cnt = 0. On a synced sync falling edge: tx_shift <= tx_data, spi_miso_o <= tx_data[MSB], miso_oe = 1, busy = 1, go to ACTIVE.
  - ACTIVE, SCLK rising edge: rx_shift <= {rx_shift[N*8-2:0], mosi}; bit_cnt++.
  - ACTIVE, SCLK falling edge: tx_shift <<= 1; spi_miso_o <= tx_shift[MSB-1]. Suppressed once bit_cnt == N*8.
  - ACTIVE, bit_cnt == N*8 and SCLK low: go to DONE.
  - ACTIVE, sync deasserted before bit_cnt == N*8: frame_error <= 1; rx_copy and tx_data untouched; go to IDLE.
  - DONE (1 cycle):
    - rx_copy <= rx_shift.
    - If rx_valid is already 1, overrun <= 1.
    - rx_valid <= 1; tx_data <= 0.
    - Go to WAIT_DESEL.
  - WAIT_DESEL: ignore SCLK; on sync high go to IDLE with miso_oe = 0. Extra clocks while selected are ignored.
- Simultaneous events:
  - DONE and an RX_BYTE read in the same cycle: DONE wins. rx_copy is loaded and rx_valid = 1; the read returns the old MSB byte; overrun is not set.
  - DONE and a TX_BYTE write in the same cycle: the write wins; tx_data holds the shifted-in byte.
  - TX_BYTE writes while busy only affect tx_data, i.e. the next frame. tx_shift is not affected.
- Reset (asynchronous, any time including mid-frame):
  - State IDLE.
  - Outputs: data_o = 0, spi_miso_o = 0, spi_miso_oe_o = 0.
  - All shift registers, tx_data, rx_copy, bit_cnt and flags = 0; synchronisers preset to idle levels (sync = 1, sclk = 0).
  - After release, a frame already in progress is not joined; the block waits for the next sync falling edge.

Test Plan:
- N=1, TX_BYTE 0xA5; master sends 0x3C → MISO bits 1,0,1,0,0,1,0,1; STATUS = 0x02; RX_BYTE returns 0x3C; then STATUS = 0x00.
- N=2, TX_BYTE 0x12 then 0x34; master sends 0xBEEF → master receives 0x1234; RX_BYTE reads give 0xBE then 0xEF.
- Two frames with no read in between (0x11, then 0x22) → STATUS = 0x06; RX_BYTE returns 0x22; CLEAR 0x04 → STATUS = 0x00.
- Sync deasserted after 5 SCLKs → STATUS bit3 = 1, rx_valid = 0; the next full frame receives correctly; CLEAR 0x08 clears the flag.
- Assert reset_ni low mid-frame (bit 4) → MISO_oe = 0 immediately, all STATUS bits 0; the remaining SCLKs before the next sync falling edge are ignored.
- 9 SCLKs in one N=1 frame → data from the first 8 bits only; rx_valid = 1; no frame_error.
